// File: rtl/spi_arbiter_pkg.sv
// Shared types and default sizing for the SPI arbiter slice.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;

    // Index of the requester after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side and SPI-master-side bus of the arbiter.
interface spi_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic [DATA_W-1:0]         rx_data;
    logic                      busy;
    logic                      m_start;
    logic [DATA_W-1:0]         m_data;
    logic                      m_finish;
    logic [DATA_W-1:0]         m_rx;

    // Arbiter side.
    modport slave (
        input  req, req_data, m_finish, m_rx,
        output grant, done, err, rx_data, busy, m_start, m_data
    );

    // Requesters and SPI master side.
    modport master (
        output req, req_data, m_finish, m_rx,
        input  grant, done, err, rx_data, busy, m_start, m_data
    );
endinterface

// File: rtl/spi_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above the
// pointer wins, wrapping to index 0.
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_valid
);
    int   w_k;
    logic w_found;

    // Scan requesters starting at the pointer; the first hit is the winner.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_k      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_k = (int'(i_ptr) + off) % NUM_REQ;
            if (!w_found && i_req[w_k]) begin
                w_found       = 1'b1;
                o_idx         = PTR_W'(w_k);
                o_onehot[w_k] = 1'b1;
            end
        end
        o_valid = w_found;
    end
endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among NUM_REQ requesters: round-robin grant,
// one-cycle start strobe, armed completion detect with timeout, and a
// one-cycle done/err report back to the owner.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    spi_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_busy;
    logic                r_m_start;
    logic [DATA_W-1:0]   r_m_data;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_winner;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_armed;

    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [PTR_W-1:0]    w_win_idx;
    logic                w_win_valid;
    logic                w_complete;
    logic                w_expire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    // A finish level only counts once it has been seen low in this WAIT,
    // so a finish left high by the previous transfer cannot end this one.
    assign w_complete = (r_state == ST_WAIT) && r_armed && bus.m_finish;
    assign w_expire   = (r_state == ST_WAIT) && !w_complete &&
                        (r_cnt == CNT_W'(TIMEOUT - 1));

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_win_valid) w_next = ST_START;
            ST_START: w_next = ST_WAIT;
            ST_WAIT:  if (w_complete || w_expire) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Registered outputs, pointer, WAIT counter and armed flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant   <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rx_data <= '0;
            r_busy    <= 1'b0;
            r_m_start <= 1'b0;
            r_m_data  <= '0;
            r_ptr     <= '0;
            r_winner  <= '0;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_m_start <= (w_next == ST_START);
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= '0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_grant  <= w_win_onehot;
                        r_winner <= w_win_idx;
                        r_m_data <= bus.req_data[int'(w_win_idx)*DATA_W +: DATA_W];
                    end else begin
                        r_grant  <= '0;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_armed <= 1'b0;
                end
                ST_WAIT: begin
                    if (w_complete || w_expire) begin
                        r_done    <= r_grant;
                        r_err     <= w_expire;
                        r_rx_data <= w_complete ? bus.m_rx : '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (!bus.m_finish) r_armed <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_grant <= '0;
                    r_ptr   <= PTR_W'(rr_next(int'(r_winner), NUM_REQ));
                end
                default: r_grant <= '0;
            endcase
        end
    end

    assign bus.grant   = r_grant;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.rx_data = r_rx_data;
    assign bus.busy    = r_busy;
    assign bus.m_start = r_m_start;
    assign bus.m_data  = r_m_data;
endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter: directed vector table, reset-abort sequence,
// then randomized transfers against a transaction-level reference model.
module tb_spi_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   m_ptr   = 0;

    spi_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    spi_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0]    rq;
        logic [NR*DW-1:0] rd;
        int               stale;
        int               delay;
        logic [DW-1:0]    rx;
        bit               drop;
        logic [NR-1:0]    eg;
        logic [DW-1:0]    em;
        logic [DW-1:0]    erx;
        bit               eerr;
    } vec_t;

    vec_t tbl [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference arbitration: first requester at or after p, wrapping.
    function automatic int model_pick(input logic [NR-1:0] rq, input int p);
        for (int k = 0; k < NR; k++)
            if (rq[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    // Finish level driven on WAIT edge e: high for the first 'stale' edges,
    // low for the next 'delay' edges, high afterwards.
    function automatic logic fin(input int e, input int stale, input int delay);
        if (e <= stale) return 1'b1;
        if (e <= stale + delay) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"},   32'(bus.grant),   32'h0);
        check({tag, "_done"},    32'(bus.done),    32'h0);
        check({tag, "_err"},     32'(bus.err),     32'h0);
        check({tag, "_rx"},      32'(bus.rx_data), 32'h0);
        check({tag, "_busy"},    32'(bus.busy),    32'h0);
        check({tag, "_mstart"},  32'(bus.m_start), 32'h0);
        check({tag, "_mdata"},   32'(bus.m_data),  32'h0);
    endtask

    // One full transfer from IDLE back to IDLE with expected results given.
    task automatic xfer(input string tag, input logic [NR-1:0] rq, input logic [NR*DW-1:0] rd,
                        input int stale, input int delay, input logic [DW-1:0] rx, input bit drop,
                        input logic [NR-1:0] eg, input logic [DW-1:0] em,
                        input logic [DW-1:0] erx, input bit eerr);
        int exp_edge;
        int early;
        bit seen0;
        exp_edge = TMO;
        seen0 = 1'b0;
        for (int e = 1; e <= TMO; e++) begin
            if (fin(e, stale, delay) && seen0) begin
                exp_edge = e;
                break;
            end
            if (!fin(e, stale, delay)) seen0 = 1'b1;
        end

        bus.m_finish = (stale > 0);
        bus.m_rx     = ~rx;
        bus.req      = rq;
        bus.req_data = rd;
        step();
        check({tag, "_grant"},  32'(bus.grant),   32'(eg));
        check({tag, "_mstart"}, 32'(bus.m_start), 32'h1);
        check({tag, "_mdata"},  32'(bus.m_data),  32'(em));
        check({tag, "_busy"},   32'(bus.busy),    32'h1);
        step();
        check({tag, "_mstart_low"}, 32'(bus.m_start), 32'h0);

        early = 0;
        for (int e = 1; e <= exp_edge; e++) begin
            bus.m_finish = fin(e, stale, delay);
            bus.m_rx     = (e > stale) ? rx : ~rx;
            if (drop && e == 2) begin
                bus.req      = rq & ~eg;
                bus.req_data = ~rd;
            end
            step();
            if (e < exp_edge && (bus.done != '0 || bus.err || bus.grant != eg || bus.m_start))
                early++;
        end
        check({tag, "_wait_quiet"}, 32'(early), 32'h0);
        check({tag, "_done"},  32'(bus.done),    32'(eg));
        check({tag, "_err"},   32'(bus.err),     32'(eerr));
        check({tag, "_rx"},    32'(bus.rx_data), 32'(erx));
        check({tag, "_grant_hold"}, 32'(bus.grant), 32'(eg));
        check({tag, "_mdata_hold"}, 32'(bus.m_data), 32'(em));

        bus.m_finish = 1'b0;
        step();
        check({tag, "_idle"}, {bus.grant, bus.done, 3'(bus.err), bus.busy}, 32'h0);
        check({tag, "_rx_keep"}, 32'(bus.rx_data), 32'(erx));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b1111, 32'h44332211, 0, 3,    8'hC1, 1'b0, 4'b0001, 8'h11, 8'hC1, 1'b0};
        tbl[1]  = '{4'b1111, 32'h44332211, 0, 5,    8'hC2, 1'b0, 4'b0010, 8'h22, 8'hC2, 1'b0};
        tbl[2]  = '{4'b1111, 32'h44332211, 0, 1,    8'hC3, 1'b0, 4'b0100, 8'h33, 8'hC3, 1'b0};
        tbl[3]  = '{4'b1111, 32'h44332211, 0, 2,    8'hC4, 1'b0, 4'b1000, 8'h44, 8'hC4, 1'b0};
        tbl[4]  = '{4'b1111, 32'h44332211, 0, 4,    8'hC5, 1'b0, 4'b0001, 8'h11, 8'hC5, 1'b0};
        tbl[5]  = '{4'b0100, 32'h44A52211, 0, 19,   8'h3C, 1'b0, 4'b0100, 8'hA5, 8'h3C, 1'b0};
        tbl[6]  = '{4'b0010, 32'h44A52211, 2, 7,    8'h5A, 1'b0, 4'b0010, 8'h22, 8'h5A, 1'b0};
        tbl[7]  = '{4'b0010, 32'h8899AABB, 0, 6,    8'h77, 1'b1, 4'b0010, 8'hAA, 8'h77, 1'b0};
        tbl[8]  = '{4'b1000, 32'h8899AABB, 0, 1000, 8'h5E, 1'b0, 4'b1000, 8'h88, 8'h00, 1'b1};
        tbl[9]  = '{4'b0001, 32'h8899AABB, 0, 2,    8'h99, 1'b0, 4'b0001, 8'hBB, 8'h99, 1'b0};
        tbl[10] = '{4'b0011, 32'h8899AABB, 0, 3,    8'h12, 1'b0, 4'b0010, 8'hAA, 8'h12, 1'b0};
        tbl[11] = '{4'b0011, 32'h8899AABB, 0, 3,    8'h34, 1'b0, 4'b0001, 8'hBB, 8'h34, 1'b0};

        bus.req      = '0;
        bus.req_data = '0;
        bus.m_finish = 1'b0;
        bus.m_rx     = '0;
        rst = 1'b1;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();
        check_reset_vals("idle_noreq");

        for (int i = 0; i < 12; i++)
            xfer($sformatf("vec%0d", i), tbl[i].rq, tbl[i].rd, tbl[i].stale, tbl[i].delay,
                 tbl[i].rx, tbl[i].drop, tbl[i].eg, tbl[i].em, tbl[i].erx, tbl[i].eerr);

        // Reset in the middle of WAIT aborts without a done pulse.
        bus.req      = 4'b0100;
        bus.req_data = 32'hDEADBEEF;
        bus.m_finish = 1'b0;
        step();
        check("rstmid_grant", 32'(bus.grant), 32'h4);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check_reset_vals("rstmid");
        rst = 1'b0;
        bus.req = '0;
        step();
        check_reset_vals("rstmid_after");
        xfer("post_rst", 4'b0101, 32'h10203040, 0, 3, 8'h6B, 1'b0, 4'b0001, 8'h40, 8'h6B, 1'b0);
        m_ptr = 1;

        // Randomized transfers checked against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [NR-1:0]    rq;
            logic [NR*DW-1:0] rd;
            logic [DW-1:0]    rx;
            int               w;
            rq = NR'($urandom_range(1, (1 << NR) - 1));
            rd = $urandom;
            rx = DW'($urandom);
            w  = model_pick(rq, m_ptr);
            xfer($sformatf("rnd%0d", n), rq, rd, int'($urandom_range(0, 2)),
                 int'($urandom_range(1, 12)), rx, ($urandom_range(0, 3) == 0),
                 NR'(1 << w), rd[w*DW +: DW], rx, 1'b0);
            m_ptr = (w + 1) % NR;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
